fetch_sequencer: RTL and testbench

- Owns the program counter for the 8-bit-instruction core.
- Drives `pc` into the instruction ROM and consumes the decoded opcode plus the redirect request coming back from decode/branch logic.
- Sequences instruction issue: normal increment, branch/jump redirect, multi-cycle memory stalls (LB/LHB/STR) and HALT.
- Sits between the top-level start/done handshake and the datapath.

---
 rtl/core_pkg.sv | 23 ++
 rtl/mem_wait_timer.sv | 32 +++
 rtl/fetch_sequencer.sv | 131 +++++++++++++
 tb/tb_fetch_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit-instruction core: opcode encodings,
// fetch sequencer state enum and opcode classification helper.
package core_pkg;

  localparam logic [3:0] LB_OP   = 4'b0000;
  localparam logic [3:0] LHB_OP  = 4'b0001;
  localparam logic [3:0] STR_OP  = 4'b0011;
  localparam logic [3:0] ADD_OP  = 4'b0111;
  localparam logic [3:0] BEQ_OP  = 4'b1011;
  localparam logic [3:0] HALT_OP = 4'b1110;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    MEMWAIT = 2'd2,
    HALTED  = 2'd3
  } seq_state_t;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == LB_OP) || (op == LHB_OP) || (op == STR_OP);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MEMWAIT cycles for the fetch sequencer; expired flags the cycle on
// which the running count reaches MEM_TIMEOUT.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [8:0] LIMIT = 9'(MEM_TIMEOUT);

  logic [7:0] count;
  logic [8:0] count_inc;

  // Compare the incremented value so the Nth stall cycle is the one that expires.
  assign count_inc = {1'b0, count} + 9'd1;
  assign expired   = (count_inc == LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count_inc[7:0];
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter owner and instruction issue sequencer.
// Optional FETCH_PERF_CNT_EN adds cycle_cnt / instr_cnt performance counters.
//
// Handshake: start is a single-cycle pulse honoured only in IDLE/HALTED;
// mem_req pulses for one cycle and mem_ack is sampled only in MEMWAIT.
module fetch_sequencer
  import core_pkg::*;
#(
  parameter int PC_W        = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [3:0]      opcode,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            mem_ack,
  output logic [PC_W-1:0] pc,
  output logic            fetch_en,
  output logic            mem_req,
  output logic            busy,
  output logic            done,
  output logic            err,
  output seq_state_t      state_dbg
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     cycle_cnt,
  output logic [31:0]     instr_cnt
`endif
);

  seq_state_t      state, state_next;
  logic [PC_W-1:0] pc_next;
  logic            err_next;
  logic            timer_clear, timer_en, timer_expired;
  logic            pc_at_max;

  assign pc_at_max = (pc == {PC_W{1'b1}});
  assign state_dbg = state;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pc    <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      err   <= err_next;
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    err_next    = err;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    case (state)
      IDLE, HALTED: begin
        if (start) begin
          state_next = RUN;
          pc_next    = '0;
          err_next   = 1'b0;
        end
      end
      RUN: begin
        // HALT and memory opcodes take priority; their redirect is ignored.
        if (opcode == HALT_OP) begin
          state_next = HALTED;
        end else if (is_mem_op(opcode)) begin
          state_next  = MEMWAIT;
          timer_clear = 1'b1;
        end else if (redirect) begin
          pc_next = redirect_pc;
        end else begin
          pc_next = pc + 1'b1;
          if (pc_at_max) err_next = 1'b1;
        end
      end
      MEMWAIT: begin
        timer_en = 1'b1;
        if (mem_ack) begin
          state_next = RUN;
          pc_next    = pc + 1'b1;
          if (pc_at_max) err_next = 1'b1;
        end else if (timer_expired) begin
          state_next = HALTED;
          err_next   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fetch_en = (state == RUN);
    mem_req  = (state == RUN) && is_mem_op(opcode) && (opcode != HALT_OP);
    busy     = (state == RUN) || (state == MEMWAIT);
    done     = (state == HALTED);
  end

`ifdef FETCH_PERF_CNT_EN
  logic restart;
  assign restart = start && ((state == IDLE) || (state == HALTED));

  // Saturating counters; both stop naturally in HALTED since busy is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt <= 32'd0;
      instr_cnt <= 32'd0;
    end else if (restart) begin
      cycle_cnt <= 32'd0;
      instr_cnt <= 32'd0;
    end else begin
      if (busy && (cycle_cnt != 32'hFFFF_FFFF)) cycle_cnt <= cycle_cnt + 32'd1;
      if (fetch_en && (instr_cnt != 32'hFFFF_FFFF)) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a 16-bit PC instance with a short memory
// timeout, plus a 4-bit PC instance for wrap and HALT coverage.
module tb_fetch_sequencer;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, redirect, mem_ack;
  logic [3:0]  opcode;
  logic [15:0] redirect_pc;
  logic [15:0] pc;
  logic        fetch_en, mem_req, busy, done, err;
  seq_state_t  state_dbg;

  logic        start_b;
  logic [3:0]  opcode_b;
  logic        redirect_b, mem_ack_b;
  logic [3:0]  redirect_pc_b;
  logic [3:0]  pc_b;
  logic        fetch_en_b, mem_req_b, busy_b, done_b, err_b;
  seq_state_t  state_dbg_b;

  int checks = 0;
  int errors = 0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt, cycle_cnt_b, instr_cnt_b;
`endif

  always #5 clk = ~clk;

  fetch_sequencer #(.PC_W(16), .MEM_TIMEOUT(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode),
    .redirect(redirect), .redirect_pc(redirect_pc), .mem_ack(mem_ack),
    .pc(pc), .fetch_en(fetch_en), .mem_req(mem_req), .busy(busy),
    .done(done), .err(err), .state_dbg(state_dbg)
`ifdef FETCH_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  fetch_sequencer #(.PC_W(4), .MEM_TIMEOUT(15)) u_small (
    .clk(clk), .reset_n(reset_n), .start(start_b), .opcode(opcode_b),
    .redirect(redirect_b), .redirect_pc(redirect_pc_b), .mem_ack(mem_ack_b),
    .pc(pc_b), .fetch_en(fetch_en_b), .mem_req(mem_req_b), .busy(busy_b),
    .done(done_b), .err(err_b), .state_dbg(state_dbg_b)
`ifdef FETCH_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt_b), .instr_cnt(instr_cnt_b)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 0; redirect = 0; mem_ack = 0; opcode = ADD_OP; redirect_pc = '0;
    start_b = 0; redirect_b = 0; mem_ack_b = 0; opcode_b = ADD_OP; redirect_pc_b = '0;
    #2;
    checks++; if (pc !== 16'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", pc); end
    checks++; if ({fetch_en, mem_req, busy, done, err} !== 5'b0) begin errors++; $display("FAIL reset_outputs: got %b expected 00000", {fetch_en, mem_req, busy, done, err}); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE); end
    #10 reset_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || pc !== 16'd0) begin errors++; $display("FAIL idle_hold: busy=%b pc=%0d expected busy=0 pc=0", busy, pc); end
  endtask

  task automatic test_straight_line();
    start = 1; step(); start = 0;
    checks++; if (pc !== 16'd0 || fetch_en !== 1'b1 || busy !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL run_entry: pc=%0d fe=%b busy=%b err=%b expected 0 1 1 0", pc, fetch_en, busy, err); end
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++; if (pc !== 16'(i) || fetch_en !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL straight_pc%0d: pc=%0d fe=%b err=%b expected pc=%0d fe=1 err=0", i, pc, fetch_en, err, i); end
    end
  endtask

  task automatic test_branch();
    opcode = BEQ_OP; redirect = 1; redirect_pc = 16'd13; step();
    checks++; if (pc !== 16'd13) begin errors++; $display("FAIL branch_13: got %0d expected 13", pc); end
    redirect_pc = 16'd6; step();
    checks++; if (pc !== 16'd6) begin errors++; $display("FAIL branch_6: got %0d expected 6", pc); end
    redirect_pc = 16'd13; step();
    opcode = LB_OP; redirect_pc = 16'd6; #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL lb_redirect_req: got %b expected 1", mem_req); end
    step();
    checks++; if (state_dbg !== MEMWAIT || pc !== 16'd13 || mem_req !== 1'b0 || fetch_en !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL lb_redirect_ignored: st=%0d pc=%0d req=%b fe=%b busy=%b expected MEMWAIT 13 0 0 1", state_dbg, pc, mem_req, fetch_en, busy); end
    redirect = 0; opcode = ADD_OP; mem_ack = 1; step(); mem_ack = 0;
    checks++; if (state_dbg !== RUN || pc !== 16'd14) begin errors++; $display("FAIL lb_ack_return: st=%0d pc=%0d expected RUN 14", state_dbg, pc); end
  endtask

  task automatic test_mem_stall();
    opcode = BEQ_OP; redirect = 1; redirect_pc = 16'd23; step();
    redirect = 0; opcode = LB_OP; mem_ack = 1; #1;
    checks++; if (mem_req !== 1'b1 || pc !== 16'd23) begin errors++; $display("FAIL stall_req: req=%b pc=%0d expected 1 23", mem_req, pc); end
    step(); mem_ack = 0; opcode = ADD_OP;
    checks++; if (state_dbg !== MEMWAIT || pc !== 16'd23) begin errors++; $display("FAIL stall_early_ack: st=%0d pc=%0d expected MEMWAIT 23", state_dbg, pc); end
    step();
    checks++; if (pc !== 16'd23 || mem_req !== 1'b0 || fetch_en !== 1'b0) begin errors++; $display("FAIL stall_mw2: pc=%0d req=%b fe=%b expected 23 0 0", pc, mem_req, fetch_en); end
    step(); mem_ack = 1;
    checks++; if (pc !== 16'd23 || state_dbg !== MEMWAIT) begin errors++; $display("FAIL stall_mw3: pc=%0d st=%0d expected 23 MEMWAIT", pc, state_dbg); end
    step(); mem_ack = 0;
    checks++; if (pc !== 16'd24 || fetch_en !== 1'b1) begin errors++; $display("FAIL stall_done: pc=%0d fe=%b expected 24 1", pc, fetch_en); end
  endtask

  task automatic test_timeout();
    opcode = BEQ_OP; redirect = 1; redirect_pc = 16'd34; step();
    redirect = 0; opcode = STR_OP; step(); opcode = ADD_OP;
    step(); step(); step();
    checks++; if (state_dbg !== MEMWAIT || done !== 1'b0) begin errors++; $display("FAIL timeout_mw4: st=%0d done=%b expected MEMWAIT 0", state_dbg, done); end
    step();
    checks++; if (done !== 1'b1 || err !== 1'b1 || pc !== 16'd34 || busy !== 1'b0 || fetch_en !== 1'b0) begin
      errors++; $display("FAIL timeout_halt: done=%b err=%b pc=%0d busy=%b fe=%b expected 1 1 34 0 0", done, err, pc, busy, fetch_en); end
    start = 1; step(); start = 0;
    checks++; if (pc !== 16'd0 || err !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL timeout_restart: pc=%0d err=%b busy=%b done=%b expected 0 0 1 0", pc, err, busy, done); end
    opcode = STR_OP; step(); opcode = ADD_OP;
    step(); step(); step(); mem_ack = 1; step(); mem_ack = 0;
    checks++; if (state_dbg !== RUN || pc !== 16'd1 || err !== 1'b0) begin errors++; $display("FAIL ack_on_timeout: st=%0d pc=%0d err=%b expected RUN 1 0", state_dbg, pc, err); end
  endtask

  task automatic test_start_ignored();
    start = 1; step(); start = 0;
    checks++; if (pc !== 16'd2 || err !== 1'b0) begin errors++; $display("FAIL start_in_run: pc=%0d err=%b expected 2 0", pc, err); end
  endtask

  task automatic test_wrap_halt();
    start_b = 1; step(); start_b = 0;
    repeat (15) step();
    checks++; if (pc_b !== 4'd15 || err_b !== 1'b0) begin errors++; $display("FAIL wrap_pre: pc=%0d err=%b expected 15 0", pc_b, err_b); end
    step();
    checks++; if (pc_b !== 4'd0 || err_b !== 1'b1 || busy_b !== 1'b1) begin errors++; $display("FAIL wrap: pc=%0d err=%b busy=%b expected 0 1 1", pc_b, err_b, busy_b); end
    step(); step();
    opcode_b = HALT_OP; step(); opcode_b = ADD_OP;
    checks++; if (done_b !== 1'b1 || pc_b !== 4'd2) begin errors++; $display("FAIL halt: done=%b pc=%0d expected 1 2", done_b, pc_b); end
    repeat (10) step();
    checks++; if (done_b !== 1'b1 || pc_b !== 4'd2 || busy_b !== 1'b0) begin errors++; $display("FAIL halt_hold: done=%b pc=%0d busy=%b expected 1 2 0", done_b, pc_b, busy_b); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (cycle_cnt_b !== 32'd19 || instr_cnt_b !== 32'd19) begin errors++; $display("FAIL perf_halt: cyc=%0d ins=%0d expected 19 19", cycle_cnt_b, instr_cnt_b); end
`endif
    start_b = 1; step(); start_b = 0;
    checks++; if (pc_b !== 4'd0 || err_b !== 1'b0 || done_b !== 1'b0) begin errors++; $display("FAIL halt_restart: pc=%0d err=%b done=%b expected 0 0 0", pc_b, err_b, done_b); end
  endtask

  task automatic test_async_reset();
    opcode = LB_OP; step();
    checks++; if (state_dbg !== MEMWAIT) begin errors++; $display("FAIL pre_reset_state: got %0d expected %0d", state_dbg, MEMWAIT); end
    #3 reset_n = 1'b0;
    #1;
    checks++; if (pc !== 16'd0 || mem_req !== 1'b0 || busy !== 1'b0 || state_dbg !== IDLE) begin
      errors++; $display("FAIL async_reset: pc=%0d req=%b busy=%b st=%0d expected 0 0 0 IDLE", pc, mem_req, busy, state_dbg); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin errors++; $display("FAIL perf_reset: cyc=%0d ins=%0d expected 0 0", cycle_cnt, instr_cnt); end
`endif
    #3 reset_n = 1'b1;
    opcode = ADD_OP;
    step();
    checks++; if (state_dbg !== IDLE || pc !== 16'd0) begin errors++; $display("FAIL post_reset_idle: st=%0d pc=%0d expected IDLE 0", state_dbg, pc); end
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_branch();
    test_mem_stall();
    test_timeout();
    test_start_ignored();
    test_wrap_halt();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
